// File: rtl/am_tx.sv
// am_tx: per-lane 40GBASE-R alignment marker inserter with BIP3/BIP7 generation
module am_tx #(
  parameter int BLOCK_W = 66,
  parameter int LANE_N  = 4,
  parameter int LANE    = 0,
  parameter int GAP_N   = 16383
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               valid_i,
  input  logic [BLOCK_W-1:0] block_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [BLOCK_W-1:0] block_o,
  output logic               am_v_o
);
  localparam int GW = $clog2(GAP_N + 1);
  function automatic logic [47:0] am_const(input int l);
    return l == 0 ? 48'hB8896F_477690 :
           l == 1 ? 48'h193B0F_E6C4F0 :
           l == 2 ? 48'h649A3A_9B65C5 : 48'hC2865D_3D79A2;
  endfunction
  localparam logic [47:0] M = am_const(LANE % LANE_N);
  function automatic logic [7:0] bip(input logic [BLOCK_W-1:0] b);
    logic [7:0] r;
    r = {3'b0, b[1], b[0], 3'b0};
    for (int j = 0; j < 8; j++) r ^= b[2+8*j +: 8];
    return r;
  endfunction
  logic [GW-1:0]      gap_q;
  logic [7:0]         bip_q;
  logic               am;
  logic [BLOCK_W-1:0] marker;
  assign am      = gap_q == '0;
  assign ready_o = !am;
  assign marker  = {~bip_q, M[47:24], bip_q, M[23:0], 2'b10};
  always_ff @(posedge clk)
    if (!nreset) begin
      gap_q   <= '0;
      bip_q   <= '0;
      valid_o <= 1'b0;
      am_v_o  <= 1'b0;
      block_o <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        am_v_o  <= am;
        block_o <= am ? marker : block_i;
        bip_q   <= am ? bip(marker) : bip_q ^ bip(block_i);
        gap_q   <= am ? GW'(1) : (gap_q == GW'(GAP_N) ? '0 : gap_q + GW'(1));
      end
    end
endmodule

// File: tb/tb_am_tx.sv
// tb_am_tx: directed vector table on GAP_N=3 lanes 0..3 plus a full-period soak on GAP_N=16383
module tb_am_tx;
  logic clk = 1'b0;
  logic nreset, valid, valid_s;
  logic [65:0] blk, block_s;
  logic rdy0, v0, am0, rdy1, v1, am1, rdy2, v2, am2, rdy3, v3, am3, rdys, vs, ams;
  logic [65:0] bo0, bo1, bo2, bo3, bos;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  am_tx #(.GAP_N(3), .LANE(0)) u0 (.clk(clk), .nreset(nreset), .valid_i(valid), .block_i(blk),
    .ready_o(rdy0), .valid_o(v0), .block_o(bo0), .am_v_o(am0));
  am_tx #(.GAP_N(3), .LANE(1)) u1 (.clk(clk), .nreset(nreset), .valid_i(valid), .block_i(blk),
    .ready_o(rdy1), .valid_o(v1), .block_o(bo1), .am_v_o(am1));
  am_tx #(.GAP_N(3), .LANE(2)) u2 (.clk(clk), .nreset(nreset), .valid_i(valid), .block_i(blk),
    .ready_o(rdy2), .valid_o(v2), .block_o(bo2), .am_v_o(am2));
  am_tx #(.GAP_N(3), .LANE(3)) u3 (.clk(clk), .nreset(nreset), .valid_i(valid), .block_i(blk),
    .ready_o(rdy3), .valid_o(v3), .block_o(bo3), .am_v_o(am3));
  am_tx #(.GAP_N(16383), .LANE(0)) us (.clk(clk), .nreset(nreset), .valid_i(valid_s), .block_i(block_s),
    .ready_o(rdys), .valid_o(vs), .block_o(bos), .am_v_o(ams));

  typedef struct {
    logic        nrst;
    logic        v;
    logic [65:0] blk;
    logic        e_v;
    logic        e_am;
    logic [65:0] e_blk;
    logic        e_rdy;
  } vec_t;
  vec_t vec[17];

  function automatic logic [65:0] mk0(input logic [7:0] b);
    return {~b, 24'hB8896F, b, 24'h477690, 2'b10};
  endfunction

  function automatic logic [7:0] tb_bip(input logic [65:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) begin
      r[k] = 1'b0;
      for (int j = 0; j < 8; j++) r[k] = r[k] ^ b[2 + k + 8*j];
    end
    r[3] = r[3] ^ b[0];
    r[4] = r[4] ^ b[1];
    return r;
  endfunction

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [65:0] D  = 66'h1;
  localparam logic [65:0] D2 = 66'h2;
  localparam logic [65:0] D3 = 66'h4;
  localparam logic [65:0] X  = 'x;

  initial begin
    logic [7:0] acc;
    logic [65:0] sent;
    logic exp_am;
    vec[0]  = '{1'b0, 1'b1, D,  1'b0, 1'b0, 66'h0,      1'b0};
    vec[1]  = '{1'b1, 1'b1, X,  1'b1, 1'b1, mk0(8'h00), 1'b1};
    vec[2]  = '{1'b1, 1'b1, D,  1'b1, 1'b0, D,          1'b1};
    vec[3]  = '{1'b1, 1'b1, D,  1'b1, 1'b0, D,          1'b1};
    vec[4]  = '{1'b1, 1'b1, D,  1'b1, 1'b0, D,          1'b0};
    vec[5]  = '{1'b1, 1'b1, X,  1'b1, 1'b1, mk0(8'h18), 1'b1};
    vec[6]  = '{1'b1, 1'b0, D,  1'b0, 1'b1, mk0(8'h18), 1'b1};
    vec[7]  = '{1'b1, 1'b1, D2, 1'b1, 1'b0, D2,         1'b1};
    vec[8]  = '{1'b1, 1'b0, D,  1'b0, 1'b0, D2,         1'b1};
    vec[9]  = '{1'b1, 1'b1, D3, 1'b1, 1'b0, D3,         1'b1};
    vec[10] = '{1'b1, 1'b0, D,  1'b0, 1'b0, D3,         1'b1};
    vec[11] = '{1'b1, 1'b1, D,  1'b1, 1'b0, D,          1'b0};
    vec[12] = '{1'b1, 1'b0, D2, 1'b0, 1'b0, D,          1'b0};
    vec[13] = '{1'b1, 1'b1, X,  1'b1, 1'b1, mk0(8'h09), 1'b1};
    vec[14] = '{1'b1, 1'b1, D,  1'b1, 1'b0, D,          1'b1};
    vec[15] = '{1'b0, 1'b1, D,  1'b0, 1'b0, 66'h0,      1'b0};
    vec[16] = '{1'b1, 1'b1, X,  1'b1, 1'b1, mk0(8'h00), 1'b1};
    nreset = 1'b0;
    valid = 1'b0;
    valid_s = 1'b0;
    blk = '0;
    block_s = '0;
    #1;
    for (int i = 0; i < 17; i++) begin
      nreset = vec[i].nrst;
      valid = vec[i].v;
      blk = vec[i].blk;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d valid_o", i), {65'b0, v0}, {65'b0, vec[i].e_v});
      check($sformatf("vec%0d am_v_o", i), {65'b0, am0}, {65'b0, vec[i].e_am});
      check($sformatf("vec%0d block_o", i), bo0, vec[i].e_blk);
      check($sformatf("vec%0d ready_o", i), {65'b0, rdy0}, {65'b0, vec[i].e_rdy});
      if (i == 1) begin
        check("lane1 marker", bo1, {8'hFF, 24'h193B0F, 8'h00, 24'hE6C4F0, 2'b10});
        check("lane2 marker", bo2, {8'hFF, 24'h649A3A, 8'h00, 24'h9B65C5, 2'b10});
        check("lane3 marker", bo3, {8'hFF, 24'hC2865D, 8'h00, 24'h3D79A2, 2'b10});
        check("lane1-3 am_v_o", {63'b0, am1, am2, am3}, 66'h7);
      end
    end
    valid = 1'b0;
    // soak instance has seen only resets so far, so slot 0 is its first marker
    acc = 8'h00;
    for (int s = 0; s <= 4 * 16384; s++) begin
      block_s = {2'($urandom()), $urandom(), $urandom()};
      sent = block_s;
      valid_s = 1'b1;
      @(posedge clk);
      #1;
      exp_am = (s % 16384) == 0;
      check($sformatf("soak%0d am_v_o", s), {65'b0, ams}, {65'b0, exp_am});
      if (exp_am) begin
        check($sformatf("soak%0d marker", s), bos, mk0(acc));
        acc = tb_bip(mk0(acc));
      end else begin
        if (bos !== sent) check($sformatf("soak%0d data", s), bos, sent);
        acc = acc ^ tb_bip(sent);
      end
    end
    valid_s = 1'b0;
    @(posedge clk);
    #1;
    check("soak idle valid_o", {65'b0, vs}, 66'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
